// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - round-robin arbiter sharing one i2c_controller between requesters
//
// Purpose: grants one of NUM_REQ requesters at a time, latches its command
// (slave address, data byte, repeated-start flag) onto the controller inputs,
// follows the transaction by watching the controller's SDA/SCL for START/STOP,
// then releases the bus with a one-cycle done pulse to the granted requester.
//
// Optional macro: I2C_ARB_TIMEOUT_EN adds a watchdog of TIMEOUT_CYCLES cycles
// over WAIT_START/ACTIVE; without it timeout_err is tied low.
//
// Ports:
//   i2c_core_clk              core clock, rising edge
//   rst_n                     synchronous active-low reset
//   req[NUM_REQ]              per-requester level request
//   req_addr[8*NUM_REQ]       packed slave address + R/W, requester i at [8i+7:8i]
//   req_data[8*NUM_REQ]       packed write data byte per requester
//   req_rsc[NUM_REQ]          per-requester repeated-start flag
//   gnt[NUM_REQ]              one-hot grant
//   done[NUM_REQ]             one-cycle completion pulse
//   busy                      arbiter not idle
//   ctrl_enable               controller enable
//   ctrl_slave_address[8]     controller slave address
//   ctrl_data_in[8]           controller data byte
//   ctrl_repeated_start_cond  controller repeated-start flag
//   mon_sda, mon_scl          controller sda_out / scl_out being monitored
//   timeout_err               one-cycle watchdog pulse

module i2c_bus_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   i2c_core_clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_rsc,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy,
  output logic                   ctrl_enable,
  output logic [7:0]             ctrl_slave_address,
  output logic [7:0]             ctrl_data_in,
  output logic                   ctrl_repeated_start_cond,
  input  logic                   mon_sda,
  input  logic                   mon_scl,
  output logic                   timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_param
    $error("i2c_bus_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, GRANT, WAIT_START, ACTIVE, RELEASE} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic               sda_q, scl_q;
  logic               start_det, stop_det;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               wd_hit;

  // START/STOP: SDA edge while SCL is high on both sides of the edge.
  assign start_det = scl_q & mon_scl &  sda_q & ~mon_sda;
  assign stop_det  = scl_q & mon_scl & ~sda_q &  mon_sda;
  assign busy      = (state != IDLE);

  // Round-robin search: first request strictly after the last winner, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && req[(int'(ptr) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // A START coinciding with the limit counts as progress, not a timeout.
  assign wd_hit = (state == WAIT_START || state == ACTIVE) && !start_det &&
                  (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i2c_core_clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == GRANT || start_det) begin
      wd_cnt <= '0;
    end else if (state == WAIT_START || state == ACTIVE) begin
      wd_cnt <= wd_cnt + 16'd1;
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge i2c_core_clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (win_found) state_next = GRANT;
      GRANT:      state_next = WAIT_START;
      WAIT_START: begin
        if (start_det)   state_next = ACTIVE;
        else if (wd_hit) state_next = RELEASE;
      end
      ACTIVE: begin
        // Repeated START keeps the bus; only STOP (or the watchdog) ends it.
        if (stop_det)    state_next = RELEASE;
        else if (wd_hit) state_next = RELEASE;
      end
      RELEASE:    state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge i2c_core_clk) begin
    if (!rst_n) begin
      sda_q                    <= 1'b1;
      scl_q                    <= 1'b1;
      ptr                      <= IDX_W'(NUM_REQ - 1);
      gnt_idx                  <= '0;
      gnt                      <= '0;
      done                     <= '0;
      ctrl_enable              <= 1'b0;
      ctrl_slave_address       <= '0;
      ctrl_data_in             <= '0;
      ctrl_repeated_start_cond <= 1'b0;
      timeout_err              <= 1'b0;
    end else begin
      sda_q       <= mon_sda;
      scl_q       <= mon_scl;
      done        <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt                      <= '0;
            gnt[win_idx]             <= 1'b1;
            gnt_idx                  <= win_idx;
            ctrl_slave_address       <= req_addr[{win_idx, 3'b000} +: 8];
            ctrl_data_in             <= req_data[{win_idx, 3'b000} +: 8];
            ctrl_repeated_start_cond <= req_rsc[win_idx];
            ctrl_enable              <= 1'b1;
          end
        end
        WAIT_START: begin
          if (start_det) begin
            ctrl_enable <= 1'b0;
          end else if (wd_hit) begin
            ctrl_enable <= 1'b0;
            timeout_err <= 1'b1;
          end
        end
        ACTIVE: begin
          if (stop_det)    done        <= gnt;
          else if (wd_hit) timeout_err <= 1'b1;
        end
        RELEASE: begin
          gnt <= '0;
          ptr <= gnt_idx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb/tb_i2c_bus_arbiter.sv - scoreboard bench for i2c_bus_arbiter

module tb_i2c_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_rsc;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic        ctrl_enable;
  logic [7:0]  ctrl_slave_address;
  logic [7:0]  ctrl_data_in;
  logic        ctrl_repeated_start_cond;
  logic        mon_sda;
  logic        mon_scl;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] g;
    logic [7:0] a;
    logic [7:0] d;
    logic       r;
  } gexp_t;

  gexp_t      gq[$];
  logic [3:0] dq[$];
  logic [3:0] gnt_prev = 4'b0;

  i2c_bus_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(4096)) dut (
    .i2c_core_clk             (clk),
    .rst_n                    (rst_n),
    .req                      (req),
    .req_addr                 (req_addr),
    .req_data                 (req_data),
    .req_rsc                  (req_rsc),
    .gnt                      (gnt),
    .done                     (done),
    .busy                     (busy),
    .ctrl_enable              (ctrl_enable),
    .ctrl_slave_address       (ctrl_slave_address),
    .ctrl_data_in             (ctrl_data_in),
    .ctrl_repeated_start_cond (ctrl_repeated_start_cond),
    .mon_sda                  (mon_sda),
    .mon_scl                  (mon_scl),
    .timeout_err              (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic gexp_t exp_for(input int idx);
    gexp_t e;
    e.g = 4'b0001 << idx;
    e.a = req_addr[8*idx +: 8];
    e.d = req_data[8*idx +: 8];
    e.r = req_rsc[idx];
    return e;
  endfunction

  // Scoreboard side: compare each new grant and each done pulse to the queues.
  always @(negedge clk) begin
    if (gnt !== 4'b0 && gnt_prev === 4'b0) begin
      if (gq.size() == 0) begin
        check("unexpected_gnt", gnt, 0);
      end else begin
        gexp_t e;
        e = gq.pop_front();
        check("sb_gnt", gnt, e.g);
        check("sb_addr", ctrl_slave_address, e.a);
        check("sb_data", ctrl_data_in, e.d);
        check("sb_rsc", ctrl_repeated_start_cond, e.r);
      end
    end
    if (done !== 4'b0) begin
      if (dq.size() == 0) check("unexpected_done", done, 0);
      else                check("sb_done", done, dq.pop_front());
    end
    if (timeout_err !== 1'b0) check("timeout_err", timeout_err, 0);
    gnt_prev = gnt;
  end

  // One complete transaction for the expected grantee: START, then STOP.
  task automatic run_txn(input logic [3:0] exp_g);
    for (int i = 0; i < 10; i++) begin
      if (gnt !== 4'b0) break;
      step();
    end
    check("txn_gnt", gnt, exp_g);
    step();                       // GRANT -> WAIT_START
    mon_sda = 1'b0;               // START
    step();
    check("txn_en_clr", ctrl_enable, 0);
    dq.push_back(exp_g);
    mon_sda = 1'b1;               // STOP
    step();
    check("txn_rel_gnt", gnt, exp_g);
    step();
    check("txn_idle_gnt", gnt, 0);
    check("txn_idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    req      = 4'b0;
    req_addr = 32'h0;
    req_data = 32'h0;
    req_rsc  = 4'b0;
    mon_sda  = 1'b1;
    mon_scl  = 1'b1;
    step();
    step();
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_en", ctrl_enable, 0);
    check("rst_addr", ctrl_slave_address, 0);
    check("rst_data", ctrl_data_in, 0);
    check("rst_rsc", ctrl_repeated_start_cond, 0);
    check("rst_tmo", timeout_err, 0);
    rst_n = 1'b1;
    step();

    // Single requester 0, one-cycle latency, req dropped while granted.
    req_addr = 32'h000000D7;
    req_data = 32'h000000AA;
    req_rsc  = 4'b0001;
    req      = 4'b0001;
    gq.push_back(exp_for(0));
    step();
    check("t1_gnt", gnt, 4'b0001);
    check("t1_addr", ctrl_slave_address, 8'hD7);
    check("t1_data", ctrl_data_in, 8'hAA);
    check("t1_rsc", ctrl_repeated_start_cond, 1);
    check("t1_en", ctrl_enable, 1);
    check("t1_busy", busy, 1);
    req      = 4'b0;
    req_addr = 32'h11111111;      // ignored while granted
    step();
    check("t1_frozen_addr", ctrl_slave_address, 8'hD7);
    check("t1_ws_en", ctrl_enable, 1);
    mon_sda = 1'b0;
    step();
    check("t1_start_en", ctrl_enable, 0);
    check("t1_active_done", done, 0);
    dq.push_back(4'b0001);
    mon_sda = 1'b1;
    step();
    check("t1_done", done, 4'b0001);
    check("t1_rel_gnt", gnt, 4'b0001);
    step();
    check("t1_idle_gnt", gnt, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_done", done, 0);

    // Repeated START inside ACTIVE keeps the grant for requester 2.
    req_addr = 32'h00A40000;
    req_data = 32'h005C0000;
    req_rsc  = 4'b0000;
    req      = 4'b0100;
    gq.push_back(exp_for(2));
    step();
    check("t2_gnt", gnt, 4'b0100);
    req = 4'b0;
    step();
    mon_sda = 1'b0;
    step();
    mon_scl = 1'b0; step();
    mon_sda = 1'b1; step();
    mon_scl = 1'b1; step();
    mon_sda = 1'b0; step();       // repeated START
    check("t2_rs_gnt", gnt, 4'b0100);
    check("t2_rs_done", done, 0);
    step();
    check("t2_rs_busy", busy, 1);
    dq.push_back(4'b0100);
    mon_sda = 1'b1;
    step();
    check("t2_done", done, 4'b0100);
    step();
    check("t2_idle_gnt", gnt, 0);

    // Reset during ACTIVE: outputs back to reset values, no done.
    req_addr = 32'h3C000000;
    req_data = 32'h99000000;
    req_rsc  = 4'b1000;
    req      = 4'b1000;
    gq.push_back(exp_for(3));
    step();
    check("t3_gnt", gnt, 4'b1000);
    step();
    mon_sda = 1'b0;
    step();
    check("t3_active_en", ctrl_enable, 0);
    rst_n   = 1'b0;
    req     = 4'b0;
    mon_sda = 1'b1;
    step();
    check("t3_rst_gnt", gnt, 0);
    check("t3_rst_busy", busy, 0);
    check("t3_rst_addr", ctrl_slave_address, 0);
    check("t3_rst_done", done, 0);
    rst_n = 1'b1;
    step();

    // All requesters held: round-robin order 0,1,2,3,0 from reset.
    req_addr = 32'h43424140;
    req_data = 32'hD3D2D1D0;
    req_rsc  = 4'b1010;
    req      = 4'b1111;
    gq.push_back(exp_for(0));
    gq.push_back(exp_for(1));
    gq.push_back(exp_for(2));
    gq.push_back(exp_for(3));
    gq.push_back(exp_for(0));
    run_txn(4'b0001);
    run_txn(4'b0010);
    run_txn(4'b0100);
    run_txn(4'b1000);
    req = 4'b0001;                // drop the rest before the fifth grant
    run_txn(4'b0001);
    req = 4'b0;

    // Foreign START/STOP while idle is ignored.
    step();
    mon_sda = 1'b0; step();
    mon_sda = 1'b1; step();
    check("t5_busy", busy, 0);
    check("t5_gnt", gnt, 0);
    step();
    check("t5_done", done, 0);

    step();
    check("gq_empty", gq.size(), 0);
    check("dq_empty", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
